multicycle_ctrl: RTL and testbench

Multi-cycle main controller for the MIPS datapath: a five-state FSM that sequences fetch, decode, execute, memory and write-back. It drives the ALU-source, register-destination and write-back selects plus PC/IR/register-file/data-memory enables. It sits beside the datapath and takes opcode/funct from the instruction register and the ALU zero flag.

---
 rtl/mips_ctrl_pkg.sv | 87 ++++++++
 rtl/ctrl_decode.sv | 125 ++++++++++++
 rtl/multicycle_ctrl.sv | 78 +++++++
 tb/tb_multicycle_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: FSM states, opcode/funct
// values, datapath select encodings and the instruction classifier.
package mips_ctrl_pkg;

   localparam logic [2:0] S_IF  = 3'd0;
   localparam logic [2:0] S_ID  = 3'd1;
   localparam logic [2:0] S_EXE = 3'd2;
   localparam logic [2:0] S_MEM = 3'd3;
   localparam logic [2:0] S_WB  = 3'd4;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ORI   = 6'h0d;
   localparam logic [5:0] OP_LUI   = 6'h0f;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;

   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUBU  = 6'h23;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_OR  = 3'b010;

   localparam logic [1:0] REGDST_RT = 2'b00;
   localparam logic [1:0] REGDST_RD = 2'b01;
   localparam logic [1:0] REGDST_RA = 2'b10;

   localparam logic [1:0] WB_ALU = 2'b00;
   localparam logic [1:0] WB_DM  = 2'b01;
   localparam logic [1:0] WB_DPC = 2'b10;

   localparam logic [1:0] PC_SEQ = 2'b00;
   localparam logic [1:0] PC_BR  = 2'b01;
   localparam logic [1:0] PC_JMP = 2'b10;
   localparam logic [1:0] PC_RS  = 2'b11;

   localparam logic [1:0] EXT_ZERO = 2'b00;
   localparam logic [1:0] EXT_SIGN = 2'b01;
   localparam logic [1:0] EXT_LUI  = 2'b10;

   typedef enum logic [3:0] {
      INS_NOP, INS_ADDU, INS_SUBU, INS_JR, INS_ORI, INS_LUI,
      INS_LW, INS_SW, INS_BEQ, INS_J, INS_JAL
   } instr_e;

   typedef struct packed {
      logic       pc_write;
      logic       ir_write;
      logic       reg_write;
      logic       mem_write;
      logic       alu_src;
      logic [1:0] reg_dst;
      logic [1:0] mem_to_reg;
      logic [1:0] pc_src;
      logic [1:0] ext_op;
      logic [2:0] alu_ctrl;
   } ctrl_t;

   function automatic instr_e decode_instr(input logic [5:0] op, input logic [5:0] fn);
      instr_e ins;
      ins = INS_NOP;
      case (op)
         OP_RTYPE: begin
            case (fn)
               FN_ADDU: ins = INS_ADDU;
               FN_SUBU: ins = INS_SUBU;
               FN_JR:   ins = INS_JR;
               default: ins = INS_NOP;
            endcase
         end
         OP_J:    ins = INS_J;
         OP_JAL:  ins = INS_JAL;
         OP_BEQ:  ins = INS_BEQ;
         OP_ORI:  ins = INS_ORI;
         OP_LUI:  ins = INS_LUI;
         OP_LW:   ins = INS_LW;
         OP_SW:   ins = INS_SW;
         default: ins = INS_NOP;
      endcase
      return ins;
   endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational control decode: (state, opcode, funct, zero) -> datapath controls
// and next state. DM_READY_EN adds dm_ready and lets MEM stall on it.
module ctrl_decode
   import mips_ctrl_pkg::*;
(
   input  logic [2:0] state,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
`ifdef DM_READY_EN
   input  logic       dm_ready,
`endif
   output ctrl_t      ctrl,
   output logic [2:0] next_state
);

   instr_e     ins;
   logic       alu_src;
   logic [1:0] ext_op;
   logic [2:0] alu_ctrl;

   assign ins = decode_instr(opcode, funct);

   // ALU source/extension/op for the instruction; reused in WB so ALUout stays valid.
   always_comb begin
      alu_src  = 1'b0;
      ext_op   = EXT_ZERO;
      alu_ctrl = ALU_ADD;
      case (ins)
         INS_SUBU, INS_BEQ: alu_ctrl = ALU_SUB;
         INS_ORI: begin
            alu_src  = 1'b1;
            alu_ctrl = ALU_OR;
         end
         INS_LUI: begin
            alu_src  = 1'b1;
            ext_op   = EXT_LUI;
            alu_ctrl = ALU_OR;
         end
         INS_LW, INS_SW: begin
            alu_src = 1'b1;
            ext_op  = EXT_SIGN;
         end
         default: ;
      endcase
   end

   always_comb begin
      next_state = S_IF;
      case (state)
         S_IF: next_state = S_ID;
         S_ID: begin
            case (ins)
               INS_J, INS_JAL, INS_JR, INS_NOP: next_state = S_IF;
               default:                         next_state = S_EXE;
            endcase
         end
         S_EXE: begin
            case (ins)
               INS_BEQ:        next_state = S_IF;
               INS_LW, INS_SW: next_state = S_MEM;
               default:        next_state = S_WB;
            endcase
         end
         S_MEM: begin
            next_state = (ins == INS_LW) ? S_WB : S_IF;
`ifdef DM_READY_EN
            if (!dm_ready) next_state = S_MEM;
`endif
         end
         default: next_state = S_IF;
      endcase
   end

   always_comb begin
      ctrl = '0;
      case (state)
         S_IF: begin
            ctrl.ir_write = 1'b1;
            ctrl.pc_write = 1'b1;
            ctrl.pc_src   = PC_SEQ;
         end
         S_ID: begin
            case (ins)
               INS_J: begin
                  ctrl.pc_write = 1'b1;
                  ctrl.pc_src   = PC_JMP;
               end
               INS_JAL: begin
                  ctrl.pc_write   = 1'b1;
                  ctrl.pc_src     = PC_JMP;
                  ctrl.reg_write  = 1'b1;
                  ctrl.reg_dst    = REGDST_RA;
                  ctrl.mem_to_reg = WB_DPC;
               end
               INS_JR: begin
                  ctrl.pc_write = 1'b1;
                  ctrl.pc_src   = PC_RS;
               end
               default: ;
            endcase
         end
         S_EXE: begin
            ctrl.alu_src  = alu_src;
            ctrl.ext_op   = ext_op;
            ctrl.alu_ctrl = alu_ctrl;
            if (ins == INS_BEQ) begin
               ctrl.pc_src   = PC_BR;
               ctrl.pc_write = zero;
            end
         end
         S_MEM: ctrl.mem_write = (ins == INS_SW);
         S_WB: begin
            ctrl.alu_src    = alu_src;
            ctrl.ext_op     = ext_op;
            ctrl.alu_ctrl   = alu_ctrl;
            ctrl.reg_write  = 1'b1;
            ctrl.reg_dst    = (ins == INS_ADDU || ins == INS_SUBU) ? REGDST_RD : REGDST_RT;
            ctrl.mem_to_reg = (ins == INS_LW) ? WB_DM : WB_ALU;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS main controller: state register and retired-instruction counter.
// Optional DM_READY_EN macro adds the dm_ready handshake on the MEM state.
module multicycle_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             zero,
`ifdef DM_READY_EN
   input  logic             dm_ready,
`endif
   output logic             PCWrite,
   output logic             IRWrite,
   output logic             RegWrite,
   output logic             MemWrite,
   output logic             ALUsrc,
   output logic [1:0]       RegDst,
   output logic [1:0]       MemtoReg,
   output logic [1:0]       PCsrc,
   output logic [1:0]       ExtOp,
   output logic [2:0]       ALUctrl,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] instret
);

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] instret_q, instret_d;
   logic [2:0]       next_state;
   ctrl_t            ctrl;

   ctrl_decode u_decode (
      .state      (state_q),
      .opcode     (opcode),
      .funct      (funct),
      .zero       (zero),
`ifdef DM_READY_EN
      .dm_ready   (dm_ready),
`endif
      .ctrl       (ctrl),
      .next_state (next_state)
   );

   // An instruction retires on any edge that returns the FSM to IF from elsewhere.
   always_comb begin
      state_d   = next_state;
      instret_d = instret_q;
      if (rst) begin
         state_d   = S_IF;
         instret_d = '0;
      end else if (next_state == S_IF && state_q != S_IF) begin
         instret_d = instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      state_q   <= state_d;
      instret_q <= instret_d;
   end

   // Write enables are suppressed while reset is held so an aborted instruction writes nothing.
   assign PCWrite  = ctrl.pc_write  & ~rst;
   assign IRWrite  = ctrl.ir_write  & ~rst;
   assign RegWrite = ctrl.reg_write & ~rst;
   assign MemWrite = ctrl.mem_write & ~rst;
   assign ALUsrc   = ctrl.alu_src;
   assign RegDst   = ctrl.reg_dst;
   assign MemtoReg = ctrl.mem_to_reg;
   assign PCsrc    = ctrl.pc_src;
   assign ExtOp    = ctrl.ext_op;
   assign ALUctrl  = ctrl.alu_ctrl;
   assign state    = state_q;
   assign instret  = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios with literal expectations
// followed by randomized instructions, resets and zero flags against a behavioural model.
module tb_multicycle_ctrl;

   localparam int CW = 4;

   localparam int K_NOP = 0, K_ADDU = 1, K_SUBU = 2, K_JR = 3, K_ORI = 4, K_LUI = 5;
   localparam int K_LW = 6, K_SW = 7, K_BEQ = 8, K_J = 9, K_JAL = 10;

   typedef struct packed {
      logic       pcw;
      logic       irw;
      logic       rw;
      logic       mw;
      logic       src;
      logic [1:0] regdst;
      logic [1:0] m2r;
      logic [1:0] pcsrc;
      logic [1:0] ext;
      logic [2:0] alu;
   } ctl_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [5:0]    opcode, funct;
   logic          zero;
`ifdef DM_READY_EN
   logic          dm_ready;
   int            dmmode = 1;
`endif
   logic          PCWrite, IRWrite, RegWrite, MemWrite, ALUsrc;
   logic [1:0]    RegDst, MemtoReg, PCsrc, ExtOp;
   logic [2:0]    ALUctrl, state;
   logic [CW-1:0] instret;

   int n_checks = 0;
   int n_fail   = 0;

   // Model state: current instruction class, cycle index into its path, retired count.
   int  m_cls   = K_NOP;
   int  m_step  = 0;
   int  m_inst  = 0;
   bit  m_valid = 0;
   int  zmode   = 2;
   logic [11:0] dq[$];

   multicycle_ctrl #(.CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
`ifdef DM_READY_EN
      .dm_ready(dm_ready),
`endif
      .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
      .ALUsrc(ALUsrc), .RegDst(RegDst), .MemtoReg(MemtoReg), .PCsrc(PCsrc),
      .ExtOp(ExtOp), .ALUctrl(ALUctrl), .state(state), .instret(instret)
   );

   always #5 clk = ~clk;

   function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
      if (op == 6'h00) begin
         if (fn == 6'h21) return K_ADDU;
         if (fn == 6'h23) return K_SUBU;
         if (fn == 6'h08) return K_JR;
         return K_NOP;
      end
      case (op)
         6'h02: return K_J;
         6'h03: return K_JAL;
         6'h04: return K_BEQ;
         6'h0d: return K_ORI;
         6'h0f: return K_LUI;
         6'h23: return K_LW;
         6'h2b: return K_SW;
         default: return K_NOP;
      endcase
   endfunction

   // Number of cycles from IF to the next IF (without memory stalls).
   function automatic int path_len(input int c);
      if (c == K_J || c == K_JAL || c == K_JR || c == K_NOP) return 2;
      if (c == K_BEQ) return 3;
      if (c == K_LW) return 5;
      return 4;
   endfunction

   function automatic int path_state(input int c, input int step);
      if (step < 3) return step;
      if (step == 3 && (c == K_LW || c == K_SW)) return 3;
      return 4;
   endfunction

   function automatic ctl_t exp_ctl(input int c, input int st, input bit z, input bit r);
      ctl_t e;
      e = '0;
      if (st == 0) begin
         e.irw = 1; e.pcw = 1;
      end else if (st == 1) begin
         if (c == K_J)   begin e.pcw = 1; e.pcsrc = 2'b10; end
         if (c == K_JR)  begin e.pcw = 1; e.pcsrc = 2'b11; end
         if (c == K_JAL) begin
            e.pcw = 1; e.pcsrc = 2'b10; e.rw = 1; e.regdst = 2'b10; e.m2r = 2'b10;
         end
      end else if (st == 2 || st == 4) begin
         case (c)
            K_SUBU, K_BEQ: e.alu = 3'b001;
            K_ORI:         begin e.src = 1; e.ext = 2'b00; e.alu = 3'b010; end
            K_LUI:         begin e.src = 1; e.ext = 2'b10; e.alu = 3'b010; end
            K_LW, K_SW:    begin e.src = 1; e.ext = 2'b01; e.alu = 3'b000; end
            default:       ;
         endcase
         if (st == 2 && c == K_BEQ) begin e.pcsrc = 2'b01; e.pcw = z; end
         if (st == 4) begin
            e.rw     = 1;
            e.regdst = (c == K_ADDU || c == K_SUBU) ? 2'b01 : 2'b00;
            e.m2r    = (c == K_LW) ? 2'b01 : 2'b00;
         end
      end else if (st == 3) begin
         e.mw = (c == K_SW);
      end
      if (r) begin e.pcw = 0; e.irw = 0; e.rw = 0; e.mw = 0; end
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_compare();
      ctl_t act, e;
      act = {PCWrite, IRWrite, RegWrite, MemWrite, ALUsrc, RegDst, MemtoReg, PCsrc, ExtOp, ALUctrl};
      e   = exp_ctl(m_cls, path_state(m_cls, m_step), zero, rst);
      chk("model_state", 32'(state), 32'(path_state(m_cls, m_step)));
      chk("model_instret", 32'(instret), 32'(m_inst));
      chk("model_ctrl", 32'(act), 32'(e));
   endtask

   // One clock cycle: pick instruction at IF, drive inputs, compare, advance the model.
   task automatic tick(input bit r);
      int sel;
      if (m_step == 0) begin
         if (dq.size() > 0) begin
            {opcode, funct} = dq.pop_front();
         end else begin
            sel    = $urandom_range(0, 11);
            funct  = 6'($urandom);
            case (sel)
               0: {opcode, funct} = {6'h00, 6'h21};
               1: {opcode, funct} = {6'h00, 6'h23};
               2: {opcode, funct} = {6'h00, 6'h08};
               3: opcode = 6'h0d;
               4: opcode = 6'h0f;
               5: opcode = 6'h23;
               6: opcode = 6'h2b;
               7: opcode = 6'h04;
               8: opcode = 6'h02;
               9: opcode = 6'h03;
               10: opcode = 6'h00;
               default: opcode = 6'($urandom);
            endcase
         end
         m_cls = classify(opcode, funct);
      end
      rst  = r;
      zero = (zmode == 2) ? 1'($urandom) : 1'(zmode);
`ifdef DM_READY_EN
      dm_ready = (dmmode == 2) ? ($urandom_range(0, 2) != 0) : 1'(dmmode);
`endif
      #1;
      if (m_valid) model_compare();
      @(posedge clk);
      if (r) begin
         m_step = 0;
         m_inst = 0;
      end else begin
`ifdef DM_READY_EN
         if (!(path_state(m_cls, m_step) == 3 && !dm_ready)) m_step++;
`else
         m_step++;
`endif
         if (m_step == path_len(m_cls)) begin
            m_step = 0;
            m_inst = (m_inst + 1) % (1 << CW);
         end
      end
      m_valid = 1;
      @(negedge clk);
   endtask

   initial begin
      rst = 1; opcode = 0; funct = 0; zero = 0;
`ifdef DM_READY_EN
      dm_ready = 1;
`endif
      @(posedge clk);
      m_valid = 1;
      @(negedge clk);
      chk("reset_state", 32'(state), 0);
      chk("reset_instret", 32'(instret), 0);
      chk("reset_irwrite_forced", 32'(IRWrite), 0);

      // addu: IF, ID, EXE, WB, back to IF
      dq.push_back({6'h00, 6'h21});
      tick(0); chk("addu_id", 32'(state), 1);
      tick(0); chk("addu_exe", 32'(state), 2);
      tick(0); chk("addu_wb", 32'(state), 4);
      chk("addu_wb_ctl", 32'({RegWrite, RegDst, MemtoReg}), 32'(5'b1_01_00));
      tick(0); chk("addu_done", 32'({state, instret}), 32'({3'd0, 4'd1}));

      // beq taken then not taken
      zmode = 1;
      dq.push_back({6'h04, 6'h15});
      tick(0); tick(0);
      chk("beq_z1_exe", 32'({state, PCWrite, PCsrc}), 32'({3'd2, 1'b1, 2'b01}));
      tick(0); chk("beq_z1_done", 32'({state, instret}), 32'({3'd0, 4'd2}));
      zmode = 0;
      dq.push_back({6'h04, 6'h00});
      tick(0); tick(0);
      chk("beq_z0_exe", 32'({state, PCWrite, PCsrc}), 32'({3'd2, 1'b0, 2'b01}));
      tick(0); chk("beq_z0_done", 32'({state, instret}), 32'({3'd0, 4'd3}));
      zmode = 2;

      // jal
      dq.push_back({6'h03, 6'h2a});
      tick(0);
      chk("jal_id", 32'({PCWrite, PCsrc, RegWrite, RegDst, MemtoReg}),
          32'({1'b1, 2'b10, 1'b1, 2'b10, 2'b10}));
      tick(0); chk("jal_done", 32'({state, instret}), 32'({3'd0, 4'd4}));

      // lw: five cycles, DM output selected in WB
      dq.push_back({6'h23, 6'h01});
      tick(0); tick(0); tick(0); tick(0);
      chk("lw_wb", 32'({state, MemtoReg, RegWrite}), 32'({3'd4, 2'b01, 1'b1}));
      tick(0); chk("lw_done", 32'({state, instret}), 32'({3'd0, 4'd5}));

      // unknown opcode: two-cycle NOP with no enables in ID
      dq.push_back({6'h3f, 6'h21});
      tick(0);
      chk("nop_id", 32'({state, PCWrite, IRWrite, RegWrite, MemWrite}), 32'({3'd1, 4'b0000}));
      tick(0); chk("nop_done", 32'({state, instret}), 32'({3'd0, 4'd6}));

`ifdef DM_READY_EN
      // sw held in MEM while dm_ready is low
      dq.push_back({6'h2b, 6'h00});
      tick(0); tick(0); tick(0);
      dmmode = 0;
      for (int i = 0; i < 3; i++) begin
         tick(0);
         chk("sw_mem_hold", 32'({state, MemWrite}), 32'({3'd3, 1'b1}));
      end
      dmmode = 1;
      tick(0); chk("sw_done", 32'({state, instret}), 32'({3'd0, 4'd7}));
`endif

      // reset asserted while lw is in MEM
      dq.push_back({6'h23, 6'h00});
      tick(0); tick(0); tick(0);
      chk("lw_in_mem", 32'(state), 3);
      tick(1);
      chk("midrst_state", 32'({state, instret}), 0);
      chk("midrst_writes", 32'({RegWrite, MemWrite}), 0);

      // counter wrap at CNT_W = 4
      for (int i = 0; i < 15; i++) dq.push_back({6'h02, 6'h00});
      for (int i = 0; i < 30; i++) tick(0);
      chk("instret_15", 32'(instret), 15);
      dq.push_back({6'h02, 6'h00});
      tick(0); tick(0);
      chk("instret_wrap", 32'(instret), 0);

      // randomized instruction stream with occasional resets
`ifdef DM_READY_EN
      dmmode = 2;
`endif
      for (int i = 0; i < 3000; i++) tick($urandom_range(0, 63) == 0);
      tick(0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
